// File: rtl/bus_term_pkg.sv
// Shared types and helpers for the bus terminal port.
package bus_term_pkg;

    localparam int unsigned ID_W      = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
    // Widest packet dest_id() can take; narrower packets are zero-extended.
    localparam int unsigned PKT_MAX_W = 64;

    // Destination ID sits in the top ID_W bits of a pkt_w-bit packet.
    function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned pkt_w);
        logic [PKT_MAX_W-1:0] shifted;
        shifted = pkt >> (pkt_w - ID_W);
        return shifted[ID_W-1:0];
    endfunction

endpackage

// File: rtl/bus_term_port_if.sv
// Host-side and bus-side signals of one terminal port.
interface bus_term_port_if #(
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned depth   = 8
);
    localparam int unsigned cnt_w = $clog2(depth + 1);

    logic               tx_valid;
    logic [pckg_sz-1:0] tx_data;
    logic               tx_ready;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               rx_valid;
    logic [pckg_sz-1:0] rx_data;
    logic               rx_ready;
    logic [cnt_w-1:0]   tx_count;
    logic [cnt_w-1:0]   rx_count;
    logic [7:0]         drop_cnt;

    // The port itself.
    modport slave (
        input  tx_valid, tx_data, pop, push, D_push, rx_ready,
        output tx_ready, pndng, D_pop, rx_valid, rx_data, tx_count, rx_count, drop_cnt
    );

    // Whoever drives host and bus traffic into the port.
    modport master (
        output tx_valid, tx_data, pop, push, D_push, rx_ready,
        input  tx_ready, pndng, D_pop, rx_valid, rx_data, tx_count, rx_count, drop_cnt
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy counter and write-while-full when a read
// frees the slot in the same cycle.
module sync_fifo #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [width-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [width-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth+1)-1:0] count
);
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr_q, rd_ptr_q;
    logic [cnt_w-1:0] count_q;
    logic             do_wr, do_rd;

    // Qualify requests against occupancy; a read makes room for a same-cycle write.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == cnt_w'(depth));
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        count   = count_q;
        rd_data = empty ? '0 : mem[rd_ptr_q];
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; rd_data is gated by empty instead.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/bus_term_port.sv
// Per-terminal port: TX FIFO toward the bus, ID-filtered RX FIFO toward the host.
module bus_term_port
    import bus_term_pkg::*;
#(
    parameter int unsigned     pckg_sz = 16,
    parameter int unsigned     depth   = 8,
    parameter logic [ID_W-1:0] my_id   = 8'h00
) (
    input logic              clk,
    input logic              reset,
    bus_term_port_if.slave   port
);
    localparam int unsigned cnt_w = $clog2(depth + 1);

    logic               tx_full, tx_empty, tx_wr;
    logic               rx_full, rx_empty, rx_wr, rx_hit, rx_drop;
    logic [pckg_sz-1:0] tx_head, rx_head;
    logic [cnt_w-1:0]   tx_cnt, rx_cnt;
    logic [7:0]         drop_cnt_q;
    logic [ID_W-1:0]    rx_dest;

    // Host writes only when not full; a pop does not open a slot for the host.
    always_comb begin
        tx_wr = port.tx_valid && !tx_full;
    end

    sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data (port.tx_data),
        .rd_en   (port.pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_cnt)
    );

    // Address filter and RX write enable; full FIFO accepts only if the host reads now.
    always_comb begin
        rx_dest = dest_id(PKT_MAX_W'(port.D_push), pckg_sz);
        rx_hit  = port.push && ((rx_dest == my_id) || (rx_dest == BCAST_ID));
        rx_wr   = rx_hit && (!rx_full || (port.rx_ready && !rx_empty));
        rx_drop = rx_hit && !rx_wr;
    end

    sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_wr),
        .wr_data (port.D_push),
        .rd_en   (port.rx_ready),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_cnt)
    );

    // Saturating count of accepted-but-dropped packets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else if (rx_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    // Drive interface outputs.
    always_comb begin
        port.tx_ready = !tx_full;
        port.pndng    = !tx_empty;
        port.D_pop    = tx_head;
        port.tx_count = tx_cnt;
        port.rx_valid = !rx_empty;
        port.rx_data  = rx_head;
        port.rx_count = rx_cnt;
        port.drop_cnt = drop_cnt_q;
    end

endmodule
